// File: rtl/matrix_alu_seq_if.sv
// Handshake/data bundle between the instruction decoder and matrix_alu_seq.
//   start, opcode, A_flat, B_flat, scalar : request side (decoder -> ALU)
//   C_flat, overflow_flag, done, busy, error : result side (ALU -> register file)
// Matrix element (i,j) sits at bits [(i*N+j)*W +: W] of each flat vector.
interface matrix_alu_seq_if #(
    parameter int N = 5,
    parameter int W = 8
);
    logic                 start;
    logic [2:0]           opcode;
    logic [N*N*W-1:0]     A_flat;
    logic [N*N*W-1:0]     B_flat;
    logic [W-1:0]         scalar;
    logic [N*N*W-1:0]     C_flat;
    logic                 overflow_flag;
    logic                 done;
    logic                 busy;
    logic                 error;

    modport master (
        output start, opcode, A_flat, B_flat, scalar,
        input  C_flat, overflow_flag, done, busy, error
    );

    modport slave (
        input  start, opcode, A_flat, B_flat, scalar,
        output C_flat, overflow_flag, done, busy, error
    );
endinterface

// File: rtl/matrix_alu_seq.sv
// Sequential NxN matrix ALU with W-bit signed elements.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset (aborts any operation, no done)
//   bus     : slave side of matrix_alu_seq_if (start/opcode/operands in,
//             C_flat/overflow_flag/done/busy/error out)
// Elementwise ops (sum, sub, opposite, transpose, scalar) finish one edge
// after acceptance; matrix multiply does one MAC per edge (N^3 edges) and
// writes each C element as soon as its dot product is complete.
module matrix_alu_seq #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    matrix_alu_seq_if.slave    bus
);
    localparam int FW = N * N * W;
    localparam int CW = $clog2(N);
    localparam int AW = 2 * W + CW;

    localparam logic [2:0] OP_SUM = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_OPP = 3'b100;
    localparam logic [2:0] OP_TRN = 3'b101;
    localparam logic [2:0] OP_SCL = 3'b110;

    localparam logic [W-1:0]  MIN_V    = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10
    } state_t;

    state_t           state_r, state_nx_s;
    logic [FW-1:0]    a_r, b_r, c_r;
    logic [W-1:0]     scalar_r;
    logic [2:0]       opcode_r;
    logic [CW-1:0]    i_r, j_r, k_r;
    logic [AW-1:0]    acc_r;
    logic             ovf_r, done_r, busy_r, err_r;

    logic [FW-1:0]    exec_c_s;
    logic             exec_ovf_s, exec_err_s;
    logic [W-1:0]     mul_a_s, mul_b_s;
    logic [2*W-1:0]   mul_prod_s;
    logic [AW-1:0]    acc_nx_s;
    logic             k_last_s, j_last_s, i_last_s, mul_last_s;

    // True when a sign-extended value still fits a W-bit signed element.
    function automatic logic fits_acc(input logic [AW-1:0] v);
        logic [AW-W:0] top;
        top = v[AW-1:W-1];
        return (top == {(AW-W+1){1'b0}}) || (top == {(AW-W+1){1'b1}});
    endfunction

    function automatic logic fits_prod(input logic [2*W-1:0] v);
        logic [W:0] top;
        top = v[2*W-1:W-1];
        return (top == {(W+1){1'b0}}) || (top == {(W+1){1'b1}});
    endfunction

    // One elementwise result: {overflow, W-bit wrapped value}.
    // Transpose arrives here with the mirrored A element already selected.
    function automatic logic [W:0] elem_op(input logic [2:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] s);
        logic [W:0]     ext;
        logic [2*W-1:0] prod;
        logic [W:0]     res;
        ext  = {(W+1){1'b0}};
        res  = {(W+1){1'b0}};
        prod = {{W{a[W-1]}}, a} * {{W{s[W-1]}}, s};
        case (op)
            OP_SUM: begin
                ext = {a[W-1], a} + {b[W-1], b};
                res = {ext[W] ^ ext[W-1], ext[W-1:0]};
            end
            OP_SUB: begin
                ext = {a[W-1], a} - {b[W-1], b};
                res = {ext[W] ^ ext[W-1], ext[W-1:0]};
            end
            OP_OPP:  res = {(a == MIN_V), {W{1'b0}} - a};
            OP_TRN:  res = {1'b0, a};
            OP_SCL:  res = {~fits_prod(prod), prod[W-1:0]};
            default: res = {(W+1){1'b0}};
        endcase
        return res;
    endfunction

    // Whole-matrix result for the single-cycle operations.
    always_comb begin
        logic [W-1:0] a_e;
        logic [W:0]   e;
        a_e        = {W{1'b0}};
        e          = {(W+1){1'b0}};
        exec_c_s   = {FW{1'b0}};
        exec_ovf_s = 1'b0;
        exec_err_s = (opcode_r == 3'b000) || (opcode_r == 3'b111);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (opcode_r == OP_TRN) begin
                    a_e = a_r[(c*N+r)*W +: W];
                end else begin
                    a_e = a_r[(r*N+c)*W +: W];
                end
                e = elem_op(opcode_r, a_e, b_r[(r*N+c)*W +: W], scalar_r);
                exec_c_s[(r*N+c)*W +: W] = e[W-1:0];
                exec_ovf_s = exec_ovf_s | e[W];
            end
        end
    end

    // Multiply-accumulate step for the current (i, j, kk) position.
    always_comb begin
        mul_a_s    = a_r[(int'(i_r)*N + int'(k_r))*W +: W];
        mul_b_s    = b_r[(int'(k_r)*N + int'(j_r))*W +: W];
        mul_prod_s = {{W{mul_a_s[W-1]}}, mul_a_s} * {{W{mul_b_s[W-1]}}, mul_b_s};
        acc_nx_s   = acc_r + {{(AW-2*W){mul_prod_s[2*W-1]}}, mul_prod_s};
        k_last_s   = (k_r == CNT_MAX);
        j_last_s   = (j_r == CNT_MAX);
        i_last_s   = (i_r == CNT_MAX);
        mul_last_s = k_last_s && j_last_s && i_last_s;
    end

    // Next-state decision for the IDLE/EXEC/MUL controller.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = (bus.opcode == OP_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nx_s = ST_IDLE;
            ST_MUL: begin
                if (mul_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, result/flag registers and multiply counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            a_r      <= {FW{1'b0}};
            b_r      <= {FW{1'b0}};
            c_r      <= {FW{1'b0}};
            scalar_r <= {W{1'b0}};
            opcode_r <= 3'b000;
            i_r      <= CNT_ZERO;
            j_r      <= CNT_ZERO;
            k_r      <= CNT_ZERO;
            acc_r    <= {AW{1'b0}};
            ovf_r    <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.A_flat;
                        b_r      <= bus.B_flat;
                        scalar_r <= bus.scalar;
                        opcode_r <= bus.opcode;
                        ovf_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        i_r      <= CNT_ZERO;
                        j_r      <= CNT_ZERO;
                        k_r      <= CNT_ZERO;
                        acc_r    <= {AW{1'b0}};
                    end
                end
                ST_EXEC: begin
                    c_r    <= exec_c_s;
                    ovf_r  <= exec_ovf_s;
                    err_r  <= exec_err_s;
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                end
                ST_MUL: begin
                    if (k_last_s) begin
                        // Dot product complete: commit element, restart sum.
                        c_r[(int'(i_r)*N + int'(j_r))*W +: W] <= acc_nx_s[W-1:0];
                        ovf_r <= ovf_r | ~fits_acc(acc_nx_s);
                        acc_r <= {AW{1'b0}};
                        k_r   <= CNT_ZERO;
                        if (j_last_s) begin
                            j_r <= CNT_ZERO;
                            i_r <= i_last_s ? CNT_ZERO : i_r + CNT_ONE;
                        end else begin
                            j_r <= j_r + CNT_ONE;
                        end
                    end else begin
                        acc_r <= acc_nx_s;
                        k_r   <= k_r + CNT_ONE;
                    end
                    if (mul_last_s) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.C_flat        = c_r;
    assign bus.overflow_flag = ovf_r;
    assign bus.done          = done_r;
    assign bus.busy          = busy_r;
    assign bus.error         = err_r;
endmodule
